pwm_breathe_multi: RTL and testbench

//   N-channel PWM generator with per-channel mode: off, static duty, sine breathe, or scaled breathe.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/breathe_lut.sv | 27 ++
 rtl/pwm_breathe_multi.sv | 160 ++++++++++++++++
 tb/tb_pwm_breathe_multi.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode encodings and the breathe-table generator
// for the multi-channel PWM block.
package pwm_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF     = 2'd0;
  localparam logic [MODE_W-1:0] MODE_STATIC  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 2'd2;
  localparam logic [MODE_W-1:0] MODE_SCALED  = 2'd3;

  // Raised-cosine sample, 0 at i=0 and full scale at half the depth.
  function automatic int sine_val(int i, int depth, int bits);
    real pi;
    real v;
    pi = 3.14159265358979;
    v  = real'((1 << bits) - 1)
       * (1.0 - $cos(2.0 * pi * real'(i) / real'(depth))) / 2.0;
    return $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/breathe_lut.sv
// breathe_lut: combinational raised-cosine ROM, one read port.
// Indices at or beyond the table depth read as zero.
module breathe_lut
  import pwm_pkg::*;
#(
  parameter int LUT_DEPTH = 100,
  parameter int IDX_BITS  = 7,
  parameter int PWM_BITS  = 6
) (
  input  logic [IDX_BITS-1:0] idx_i,
  output logic [PWM_BITS-1:0] val_o
);

  logic [PWM_BITS-1:0] tab [LUT_DEPTH];

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_tab
    assign tab[g] = PWM_BITS'(sine_val(g, LUT_DEPTH, PWM_BITS));
  end

  always_comb begin
    val_o = '0;
    for (int k = 0; k < LUT_DEPTH; k++) begin
      if (idx_i == IDX_BITS'(k)) val_o = tab[k];
    end
  end

endmodule

// File: rtl/pwm_breathe_multi.sv
// pwm_breathe_multi: N-channel PWM with off/static/breathe/scaled modes;
// duty updates are handshaked and take effect only at a period boundary.
module pwm_breathe_multi
  import pwm_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  PWM_BITS  = 6,
  parameter int  LUT_DEPTH = 100,
  parameter int  IDX_BITS  = 7,
  parameter int  DIV_BITS  = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  input  logic [IDX_BITS-1:0] cfg_phase,
  input  logic [DIV_BITS-1:0] step_div,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                period_start
);

  localparam int CHX = 2 ** CH_W;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [IDX_BITS:0]   DEPTH   = (IDX_BITS + 1)'(LUT_DEPTH);
  localparam logic [IDX_BITS-1:0] LAST    = IDX_BITS'(LUT_DEPTH - 1);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [IDX_BITS-1:0] phase_q, phase_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [NUM_CH-1:0]   pend_q, pend_d, wr, pwm_q, pwm_d;
  logic [CHX-1:0]      pend_x, wr_x;
  logic                ps_q, boundary, accept;
  logic [IDX_BITS-1:0] off_in;
  logic [PWM_BITS-1:0] eff [NUM_CH];

  assign boundary     = ena & (cnt_q == CNT_MAX);
  // Channels beyond NUM_CH see a never-pending slot: always ready, dropped.
  assign pend_x       = CHX'(pend_q);
  assign cfg_ready    = ~pend_x[cfg_ch];
  assign accept       = cfg_valid & cfg_ready;
  assign wr_x         = CHX'(accept) << cfg_ch;
  assign wr           = NUM_CH'(wr_x);
  assign off_in       = IDX_BITS'({1'b0, cfg_phase} % DEPTH);
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    div_d   = div_q;
    pend_d  = pend_q;
    if (ena) cnt_d = cnt_q + PWM_BITS'(1);
    if (boundary) begin
      pend_d = '0;
      if (div_q >= step_div) begin
        div_d   = '0;
        phase_d = (phase_q == LAST) ? '0 : phase_q + IDX_BITS'(1);
      end else begin
        div_d = div_q + DIV_BITS'(1);
      end
    end
    pend_d = pend_d | wr;
  end

  always_comb begin
    pwm_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pwm_d[c] = ena & (eff[c] > cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
      div_q   <= '0;
      pend_q  <= '0;
      pwm_q   <= '0;
      ps_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      pwm_q   <= pwm_d;
      ps_q    <= boundary;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [MODE_W-1:0]     sh_mode_q, act_mode_q, mode_d;
    logic [PWM_BITS-1:0]   sh_duty_q, act_duty_q, duty_d;
    logic [IDX_BITS-1:0]   sh_off_q, act_off_q, off_d, idx;
    logic [PWM_BITS-1:0]   lut_v, eff_q, eff_d;
    logic [IDX_BITS:0]     sum;
    logic [2*PWM_BITS-1:0] prod;
    logic                  apply;

    // eff is latched from the settings that become active this boundary.
    assign apply  = boundary & pend_q[g];
    assign mode_d = apply ? sh_mode_q : act_mode_q;
    assign duty_d = apply ? sh_duty_q : act_duty_q;
    assign off_d  = apply ? sh_off_q  : act_off_q;
    assign sum    = {1'b0, phase_q} + {1'b0, off_d};
    assign idx    = (sum >= DEPTH) ? IDX_BITS'(sum - DEPTH)
                                   : IDX_BITS'(sum);
    assign prod   = {{PWM_BITS{1'b0}}, lut_v}
                  * {{PWM_BITS{1'b0}}, duty_d};
    assign eff[g] = eff_q;

    breathe_lut #(
      .LUT_DEPTH (LUT_DEPTH),
      .IDX_BITS  (IDX_BITS),
      .PWM_BITS  (PWM_BITS)
    ) u_lut (
      .idx_i (idx),
      .val_o (lut_v)
    );

    always_comb begin
      eff_d = '0;
      unique case (mode_d)
        MODE_OFF:     eff_d = '0;
        MODE_STATIC:  eff_d = duty_d;
        MODE_BREATHE: eff_d = lut_v;
        MODE_SCALED:  eff_d = PWM_BITS'(prod >> PWM_BITS);
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_mode_q  <= MODE_OFF;
        sh_duty_q  <= '0;
        sh_off_q   <= '0;
        act_mode_q <= MODE_OFF;
        act_duty_q <= '0;
        act_off_q  <= '0;
        eff_q      <= '0;
      end else begin
        if (wr[g]) begin
          sh_mode_q <= cfg_mode;
          sh_duty_q <= cfg_duty;
          sh_off_q  <= off_in;
        end
        if (apply) begin
          act_mode_q <= sh_mode_q;
          act_duty_q <= sh_duty_q;
          act_off_q  <= sh_off_q;
        end
        if (boundary) eff_q <= eff_d;
      end
    end
  end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// tb_pwm_breathe_multi: directed vectors and corner sequences for
// pwm_breathe_multi, measured as high cycles per PWM period.
module tb_pwm_breathe_multi;

  logic       clk = 1'b0;
  logic       rst_n, ena, cfg_valid, cfg_ready, period_start;
  logic [1:0] cfg_ch, cfg_mode;
  logic [5:0] cfg_duty;
  logic [6:0] cfg_phase;
  logic [7:0] step_div;
  logic [3:0] pwm_out;

  int checks = 0;
  int errors = 0;

  pwm_breathe_multi dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_duty     (cfg_duty),
    .cfg_phase    (cfg_phase),
    .step_div     (step_div),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Per-period high-cycle counter; a period closes on the period_start sample.
  int acc [4];
  int last_hc [4];
  int pcount = 0;
  int plen = 0;
  int plen_acc = 0;

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) acc[c] = acc[c] + int'(pwm_out[c]);
    plen_acc = plen_acc + 1;
    if (period_start) begin
      for (int c = 0; c < 4; c++) begin
        last_hc[c] = acc[c];
        acc[c] = 0;
      end
      plen = plen_acc;
      plen_acc = 0;
      pcount = pcount + 1;
    end
  end

  typedef struct {
    logic [1:0] ch;
    logic [1:0] mode;
    logic [5:0] duty;
    logic [6:0] ph;
    int         exp_hc;
    string      name;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic [1:0] ch, logic [1:0] mode,
                              logic [5:0] duty, logic [6:0] ph,
                              int exp_hc, string name);
    vec_t v;
    v.ch = ch; v.mode = mode; v.duty = duty; v.ph = ph;
    v.exp_hc = exp_hc; v.name = name;
    return v;
  endfunction

  function automatic int lut_ref(int i);
    real v;
    v = 63.0 * (1.0 - $cos(6.283185307179586 * real'(i) / 100.0)) / 2.0;
    return int'($floor(v + 0.5));
  endfunction

  task automatic check(string name, int act, int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic next_period();
    int start = pcount;
    int n = 0;
    while (pcount == start && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("period_seen", int'(pcount != start), 1);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [5:0] duty, input logic [6:0] ph,
                           output int stalls, output int ps);
    cfg_ch = ch; cfg_mode = mode; cfg_duty = duty; cfg_phase = ph;
    cfg_valid = 1'b1;
    stalls = 0;
    while (!cfg_ready && stalls < 300) begin
      @(negedge clk); #1;
      stalls++;
    end
    ps = int'(period_start);
    check("ready_at_accept", int'(cfg_ready), 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int st, ps, n, k;
    vecs[0]  = mk(0, 1, 16, 0,   16, "static16");
    vecs[1]  = mk(0, 1, 0,  0,   0,  "static0");
    vecs[2]  = mk(0, 1, 63, 0,   63, "static63");
    vecs[3]  = mk(0, 1, 1,  0,   1,  "static1");
    vecs[4]  = mk(2, 1, 40, 0,   40, "ch2_static40");
    vecs[5]  = mk(0, 0, 50, 0,   0,  "off_ignores_duty");
    vecs[6]  = mk(1, 2, 0,  10,  6,  "breathe_off10");
    vecs[7]  = mk(1, 2, 0,  20,  22, "breathe_off20");
    vecs[8]  = mk(3, 2, 0,  120, 22, "breathe_off120_mod");
    vecs[9]  = mk(2, 3, 32, 50,  31, "scaled_peak_d32");
    vecs[10] = mk(2, 3, 63, 50,  62, "scaled_peak_d63");
    vecs[11] = mk(3, 3, 16, 40,  14, "scaled_off40_d16");
    vecs[12] = mk(1, 2, 0,  50,  63, "breathe_peak");
    vecs[13] = mk(0, 2, 0,  0,   0,  "breathe_trough");

    // Large divider keeps phase at 0 through the vector section.
    rst_n = 1'b1; ena = 1'b1; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_mode = '0; cfg_duty = '0; cfg_phase = '0; step_div = 8'd255;
    #1 rst_n = 1'b0;
    #2;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      next_period();
      cfg_write(vecs[i].ch, vecs[i].mode, vecs[i].duty, vecs[i].ph, st, ps);
      check({vecs[i].name, "_stall"}, st, 0);
      next_period();
      next_period();
      check(vecs[i].name, last_hc[vecs[i].ch], vecs[i].exp_hc);
    end

    // Back-to-back writes to ch1: second one waits for the boundary.
    next_period();
    cfg_write(2'd1, 2'd1, 6'd10, 7'd0, st, ps);
    check("hs_ready_low", int'(cfg_ready), 0);
    cfg_write(2'd1, 2'd1, 6'd20, 7'd0, st, ps);
    check("hs_stall_cycles", st, 64);
    check("hs_accept_after_boundary", ps, 1);
    next_period();
    check("hs_first_duty", last_hc[1], 10);
    next_period();
    check("hs_second_duty", last_hc[1], 20);

    // ena low for 10 cycles mid-period, with a write accepted meanwhile.
    next_period();
    cfg_write(2'd0, 2'd1, 6'd63, 7'd0, st, ps);
    next_period();
    next_period();
    repeat (5) @(posedge clk);
    #1;
    ena = 1'b0;
    cfg_ch = 2'd2; cfg_mode = 2'd1; cfg_duty = 6'd5; cfg_phase = '0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      check("ena_low_out", int'(pwm_out), 0);
    end
    check("ena_low_write_pending", int'(cfg_ready), 0);
    ena = 1'b1;
    next_period();
    check("ena_period_len", plen, 74);
    check("ena_high_cycles", last_hc[0], 63);
    next_period();
    check("ena_write_applied", last_hc[2], 5);
    check("ena_next_len", plen, 64);

    // Write accepted exactly on the boundary cycle of ch3.
    next_period();
    repeat (63) @(posedge clk);
    #1;
    cfg_write(2'd3, 2'd1, 6'd33, 7'd0, st, ps);
    check("coll_on_boundary", int'(period_start), 1);
    check("coll_still_pending", int'(cfg_ready), 0);
    next_period();
    next_period();
    check("coll_not_yet", last_hc[3], 14);
    next_period();
    check("coll_applied", last_hc[3], 33);

    // Asynchronous reset in the middle of a period.
    next_period();
    repeat (3) @(posedge clk);
    #1;
    cfg_write(2'd1, 2'd1, 6'd7, 7'd0, st, ps);
    check("pre_rst_out", int'(pwm_out[0]), 1);
    check("pre_rst_ready", int'(cfg_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pwm_out", int'(pwm_out), 0);
    check("mid_rst_period_start", int'(period_start), 0);
    check("mid_rst_cfg_ready", int'(cfg_ready), 1);
    step_div = 8'd0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Breathe sweep: ch0 offset 0, ch1 offset 50, phase steps every period.
    cfg_write(2'd0, 2'd2, 6'd0, 7'd0, st, ps);
    cfg_write(2'd1, 2'd2, 6'd0, 7'd50, st, ps);
    n = 0;
    while (!period_start && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    // Two cycles were spent on writes, so 62 more reach cnt=63.
    check("post_rst_first_period", n, 63);
    for (int p = 1; p <= 101; p++) begin
      next_period();
      k = (p - 1) % 100;
      check($sformatf("br_ch0_p%0d", p), last_hc[0], lut_ref(k));
      check($sformatf("br_ch1_p%0d", p), last_hc[1], lut_ref((k + 50) % 100));
      if (p == 11) check("br_hand_lut10", last_hc[0], 6);
      if (p == 41) check("br_hand_lut40", last_hc[0], 57);
      if (p == 51) check("br_hand_lut50", last_hc[0], 63);
      if (p == 100) check("br_hand_lut99", last_hc[0], 0);
      if (p == 101) check("br_wrap_ch1", last_hc[1], 63);
    end
    check("br_ch2_off", last_hc[2], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
